// File: rtl/dz_pkg.sv
// Shared types and glyph table for the dot-matrix scan controller.
// Glyph rows are 8 columns wide. Row 0 is a spacer and is always dark.
package dz_pkg;

    typedef enum logic [1:0] {
        COL_OFF = 2'b00,
        COL_RED = 2'b01,
        COL_GRN = 2'b10,
        COL_YEL = 2'b11
    } color_e;

    localparam logic [3:0] NUM_BLANK = 4'hF;
    localparam logic [3:0] NUM_MAX   = 4'd9;

    typedef struct packed {
        logic [3:0] num;
        color_e     color;
        logic       blink;
    } content_t;

    // Indexed as [digit][row]. Codes 10-15 are all dark, so NUM_BLANK displays nothing.
    localparam logic [7:0] GLYPH_ROM [16][8] = '{
        '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h66, 8'h66, 8'h66, 8'h3C},
        '{8'h00, 8'h08, 8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h3C},
        '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h7E},
        '{8'h00, 8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C},
        '{8'h00, 8'h0C, 8'h1C, 8'h2C, 8'h4C, 8'h7E, 8'h0C, 8'h0C},
        '{8'h00, 8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C},
        '{8'h00, 8'h3C, 8'h60, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C},
        '{8'h00, 8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30},
        '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C},
        '{8'h00, 8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h06, 8'h3C},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00}
    };

endpackage

// File: rtl/dz_glyph_rom.sv
// Combinational glyph lookup: (digit, row) -> 8-bit column pattern.
module dz_glyph_rom
    import dz_pkg::*;
(
    input  logic [3:0] i_num,
    input  logic [2:0] i_row,
    output logic [7:0] o_cols
);

    assign o_cols = GLYPH_ROM[i_num][i_row];

endmodule

// File: rtl/dz_scan_ctrl.sv
// Row-multiplexed 8x8 red/green dot-matrix driver for one digit with colour and blink.
// Content changes only at frame boundaries. All outputs are registered one cycle behind the scan state.
module dz_scan_ctrl
    import dz_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int ROWS           = 8,
    parameter int BLINK_HALF     = 32,
    parameter bit ROW_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [3:0]      num,
    input  logic [1:0]      color,
    input  logic            blink_en,
    output logic [ROWS-1:0] row,
    output logic [7:0]      colr,
    output logic [7:0]      colg,
    output logic            frame_start,
    output logic            num_err
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [ROWS-1:0] ROW_IDLE = {ROWS{ROW_ACTIVE_LOW}};

    logic [PW-1:0]   r_presc;
    logic [RW-1:0]   r_row_idx;
    logic [FW-1:0]   r_frame_cnt;
    logic            r_blink_phase;
    logic            r_bnd_d;
    content_t        r_pend;
    content_t        r_disp;
    logic [ROWS-1:0] r_row;
    logic [7:0]      r_colr;
    logic [7:0]      r_colg;
    logic            r_frame_start;
    logic            r_num_err;

    logic            w_presc_wrap;
    logic            w_frame_bnd;
    logic            w_num_bad;
    logic            w_blank;
    content_t        w_load_val;
    logic [7:0]      w_glyph;
    logic [ROWS-1:0] w_row_onehot;

    assign w_presc_wrap = (r_presc == PW'(SCAN_DIV - 1));
    assign w_frame_bnd  = w_presc_wrap && (r_row_idx == RW'(ROWS - 1));
    assign w_num_bad    = (num > NUM_MAX);

    always_comb begin
        w_load_val       = '0;
        w_load_val.num   = w_num_bad ? NUM_BLANK : num;
        w_load_val.color = color_e'(color);
        w_load_val.blink = blink_en;
    end

    // Prescaler value 0 is the anti-ghosting deadtime after each row switch.
    assign w_blank      = (r_presc == '0) || (r_disp.blink && r_blink_phase);
    assign w_row_onehot = ROWS'(1) << r_row_idx;

    dz_glyph_rom u_rom (
        .i_num  (r_disp.num),
        .i_row  (3'(r_row_idx)),
        .o_cols (w_glyph)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc       <= '0;
            r_row_idx     <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_bnd_d       <= 1'b0;
        end else begin
            r_bnd_d <= w_frame_bnd;
            if (w_presc_wrap) begin
                r_presc   <= '0;
                r_row_idx <= (r_row_idx == RW'(ROWS - 1)) ? '0 : r_row_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            if (w_frame_bnd) begin
                if (r_frame_cnt == FW'(BLINK_HALF - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // A load on the boundary cycle bypasses pending so it is not delayed a whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend    <= '0;
            r_disp    <= '0;
            r_num_err <= 1'b0;
        end else begin
            if (load) r_pend <= w_load_val;
            if (w_frame_bnd) r_disp <= load ? w_load_val : r_pend;
            if (load && w_num_bad) r_num_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row         <= ROW_IDLE;
            r_colr        <= '0;
            r_colg        <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_row         <= ROW_ACTIVE_LOW ? ~w_row_onehot : w_row_onehot;
            r_colr        <= (!w_blank && (r_disp.color inside {COL_RED, COL_YEL})) ? w_glyph : '0;
            r_colg        <= (!w_blank && (r_disp.color inside {COL_GRN, COL_YEL})) ? w_glyph : '0;
            r_frame_start <= r_bnd_d;
        end
    end

    assign row         = r_row;
    assign colr        = r_colr;
    assign colg        = r_colg;
    assign frame_start = r_frame_start;
    assign num_err     = r_num_err;

endmodule
